// File: rtl/xor4_sweep_ctrl_v.sv
// rtl/xor4_sweep_ctrl_v.sv - self-test sweep sequencer and checker for a 4-input XOR gate
//
// Purpose:
//   On a start pulse in IDLE, drives all 16 input combinations onto an XOR4 gate
//   in ascending order. Each vector is held for DWELL_CYCLES clocks. The gate
//   output is sampled on the last dwell edge and compared with the odd parity of
//   the vector. Mismatches are counted, and pass/fail is reported with a
//   start/busy/done handshake.
//
// Ports:
//   i_clk      system clock, rising edge
//   i_rst      synchronous reset, active-high
//   i_start    start request, honoured only in IDLE
//   i_f        output of the XOR4 gate under test
//   o_a..o_d   gate inputs, vec[3]..vec[0], driven only while sweeping
//   o_vec      current vector index
//   o_busy     high while sweeping
//   o_done     single-cycle pulse at sweep end
//   o_pass     1 if the last sweep had zero mismatches, held until next start
//   o_err_cnt  mismatch count of the current/last sweep, 0..16

module xor4_sweep_ctrl_v #(
    parameter int DWELL_CYCLES = 4,
    parameter int CNT_W        = 8
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic       i_f,
    output logic       o_a,
    output logic       o_b,
    output logic       o_c,
    output logic       o_d,
    output logic [3:0] o_vec,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_pass,
    output logic [4:0] o_err_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);

    state_t           state_q, state_d;
    logic [3:0]       vec_q, vec_d;
    logic [CNT_W-1:0] dwell_q, dwell_d;
    logic [3:0]       gate_q, gate_d;     // {a, b, c, d}
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [4:0]       err_cnt_q, err_cnt_d;

    logic             dwell_end;
    logic             exp_f;
    logic             mismatch;
    logic [4:0]       err_cnt_next;
    logic [3:0]       vec_inc;

    // Expected gate output is the odd parity of the vector currently applied.
    assign exp_f        = vec_q[3] ^ vec_q[2] ^ vec_q[1] ^ vec_q[0];
    assign mismatch     = (i_f != exp_f);
    assign dwell_end    = (dwell_q == DWELL_LAST);
    assign err_cnt_next = err_cnt_q + {4'd0, mismatch};
    assign vec_inc      = vec_q + 4'd1;

    always_comb begin
        state_d   = state_q;
        vec_d     = vec_q;
        dwell_d   = dwell_q;
        gate_d    = gate_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        pass_d    = pass_q;
        err_cnt_d = err_cnt_q;

        case (state_q)
            ST_IDLE: begin
                gate_d = 4'd0;
                busy_d = 1'b0;
                if (i_start) begin
                    state_d   = ST_RUN;
                    vec_d     = 4'd0;
                    dwell_d   = '0;
                    err_cnt_d = 5'd0;
                    pass_d    = 1'b0;
                    busy_d    = 1'b1;
                    gate_d    = 4'd0;
                end
            end

            ST_RUN: begin
                if (dwell_end) begin
                    err_cnt_d = err_cnt_next;
                    if (vec_q == 4'hF) begin
                        // Pass uses the updated count so the final vector's
                        // compare is included.
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        gate_d  = 4'd0;
                        pass_d  = (err_cnt_next == 5'd0);
                    end else begin
                        vec_d   = vec_inc;
                        dwell_d = '0;
                        gate_d  = vec_inc;
                    end
                end else begin
                    dwell_d = dwell_q + CNT_W'(1);
                end
            end

            ST_DONE: begin
                // Start is deliberately ignored here; a new sweep needs IDLE.
                state_d = ST_IDLE;
                gate_d  = 4'd0;
                busy_d  = 1'b0;
            end

            default: begin
                state_d = ST_IDLE;
                gate_d  = 4'd0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            vec_q     <= 4'd0;
            dwell_q   <= '0;
            gate_q    <= 4'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            err_cnt_q <= 5'd0;
        end else begin
            state_q   <= state_d;
            vec_q     <= vec_d;
            dwell_q   <= dwell_d;
            gate_q    <= gate_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign o_a       = gate_q[3];
    assign o_b       = gate_q[2];
    assign o_c       = gate_q[1];
    assign o_d       = gate_q[0];
    assign o_vec     = vec_q;
    assign o_busy    = busy_q;
    assign o_done    = done_q;
    assign o_pass    = pass_q;
    assign o_err_cnt = err_cnt_q;

endmodule

// File: tb/tb_xor4_sweep_ctrl_v.sv
// tb/tb_xor4_sweep_ctrl_v.sv - self-checking bench for xor4_sweep_ctrl_v
module tb_xor4_sweep_ctrl_v;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Gate model selector shared by both instances: 0 golden XOR, 1 tied 0, 2 XNOR.
    int mode = 0;

    logic       rst4, start4, f4;
    logic       a4, b4, c4, d4, busy4, done4, pass4;
    logic [3:0] vec4;
    logic [4:0] err4;

    logic       rst1, start1, f1;
    logic       a1, b1, c1, d1, busy1, done1, pass1;
    logic [3:0] vec1;
    logic [4:0] err1;

    always_comb begin
        case (mode)
            1:       f4 = 1'b0;
            2:       f4 = ~(a4 ^ b4 ^ c4 ^ d4);
            default: f4 = a4 ^ b4 ^ c4 ^ d4;
        endcase
        case (mode)
            1:       f1 = 1'b0;
            2:       f1 = ~(a1 ^ b1 ^ c1 ^ d1);
            default: f1 = a1 ^ b1 ^ c1 ^ d1;
        endcase
    end

    xor4_sweep_ctrl_v #(.DWELL_CYCLES(4), .CNT_W(8)) dut4 (
        .i_clk(clk), .i_rst(rst4), .i_start(start4), .i_f(f4),
        .o_a(a4), .o_b(b4), .o_c(c4), .o_d(d4), .o_vec(vec4),
        .o_busy(busy4), .o_done(done4), .o_pass(pass4), .o_err_cnt(err4)
    );

    xor4_sweep_ctrl_v #(.DWELL_CYCLES(1), .CNT_W(8)) dut1 (
        .i_clk(clk), .i_rst(rst1), .i_start(start1), .i_f(f1),
        .o_a(a1), .o_b(b1), .o_c(c1), .o_d(d1), .o_vec(vec1),
        .o_busy(busy1), .o_done(done1), .o_pass(pass1), .o_err_cnt(err1)
    );

    // Instance selector for the sweep task: 0 -> dut4, 1 -> dut1.
    logic       sel = 1'b0;
    logic       cur_busy, cur_done, cur_pass;
    logic [3:0] cur_vec, cur_gate;
    logic [4:0] cur_err;
    logic [15:0] all4;

    assign cur_busy = sel ? busy1 : busy4;
    assign cur_done = sel ? done1 : done4;
    assign cur_pass = sel ? pass1 : pass4;
    assign cur_vec  = sel ? vec1  : vec4;
    assign cur_gate = sel ? {a1, b1, c1, d1} : {a4, b4, c4, d4};
    assign cur_err  = sel ? err1  : err4;
    assign all4     = {a4, b4, c4, d4, vec4, busy4, done4, pass4, err4};

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic set_start(input logic v);
        if (sel) start1 = v; else start4 = v;
    endtask

    // Runs one sweep on the selected instance, starting from IDLE at a negedge.
    // Cycle index 1 is the first cycle after the accepting edge.
    task automatic run_sweep(input string tag, input int dwell, input bit poke,
                             input int exp_err, input int exp_pass);
        int busy_cycles = 0;
        int done_cnt = 0;
        int done_pos = -1;
        int vec_bad = 0;
        int exp_vec;
        set_start(1'b1);
        @(negedge clk);
        set_start(1'b0);
        for (int cyc = 1; cyc <= 16 * dwell + 12; cyc++) begin
            set_start(1'b0);
            if (cur_busy) begin
                busy_cycles++;
                exp_vec = (cyc - 1) / dwell;
                if (int'(cur_vec) != exp_vec || cur_gate != cur_vec) vec_bad++;
            end else if (cur_gate != 4'd0) begin
                vec_bad++;
            end
            if (cur_done) begin
                done_cnt++;
                done_pos = cyc;
                if (poke) set_start(1'b1);
            end
            if (poke && cyc == 5 * dwell + 2) set_start(1'b1);
            @(negedge clk);
        end
        set_start(1'b0);
        chk({tag, " busy_cycles"}, busy_cycles, 16 * dwell);
        chk({tag, " done_count"}, done_cnt, 1);
        chk({tag, " done_cycle"}, done_pos, 16 * dwell + 1);
        chk({tag, " vector_steps"}, vec_bad, 0);
        chk({tag, " err_cnt"}, int'(cur_err), exp_err);
        chk({tag, " pass"}, int'(cur_pass), exp_pass);
    endtask

    typedef struct {
        string tag;
        bit    sel;
        int    mode;
        bit    poke;
        int    exp_err;
        int    exp_pass;
    } vec_t;

    vec_t tbl[6];

    initial begin
        tbl[0] = '{"golden_d4", 1'b0, 0, 1'b0, 0,  1};
        tbl[1] = '{"tied0_d4",  1'b0, 1, 1'b0, 8,  0};
        tbl[2] = '{"xnor_d4",   1'b0, 2, 1'b0, 16, 0};
        tbl[3] = '{"poke_d4",   1'b0, 0, 1'b1, 0,  1};
        tbl[4] = '{"golden_d1", 1'b1, 0, 1'b0, 0,  1};
        tbl[5] = '{"b2b_d1",    1'b1, 0, 1'b0, 0,  1};

        // Reset held two cycles with start high.
        rst4 = 1'b1; rst1 = 1'b1; start4 = 1'b1; start1 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_outputs", int'(all4), 0);
        rst4 = 1'b0; rst1 = 1'b0; start4 = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_no_busy", int'(busy4), 0);
        chk("reset_still_zero", int'(all4), 0);

        for (int i = 0; i < 6; i++) begin
            sel  = tbl[i].sel;
            mode = tbl[i].mode;
            #1;
            run_sweep(tbl[i].tag, sel ? 1 : 4, tbl[i].poke, tbl[i].exp_err, tbl[i].exp_pass);
            // Persistence in IDLE after DONE.
            repeat (2) @(negedge clk);
            chk({tbl[i].tag, " held_err"}, int'(cur_err), tbl[i].exp_err);
        end

        // Reset mid-sweep at vector 7 with a stuck-at-0 gate.
        sel = 1'b0; mode = 1;
        begin
            int waited = 0;
            start4 = 1'b1;
            @(negedge clk);
            start4 = 1'b0;
            while (vec4 != 4'd7 && waited < 200) begin
                @(negedge clk);
                waited++;
            end
            chk("reach_vec7", int'(vec4), 7);
            // Vectors 1, 2 and 4 have odd parity and fail against a stuck-at-0 gate.
            chk("err_at_vec7", int'(err4), 3);
            rst4 = 1'b1;
            @(negedge clk);
            rst4 = 1'b0;
            chk("midreset_outputs", int'(all4), 0);
            @(negedge clk);
            chk("midreset_idle", int'(busy4), 0);
        end
        mode = 0;
        #1;
        run_sweep("after_reset", 4, 1'b0, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
